mult_ctrl: RTL and testbench
============================

// Module: mult_ctrl
// PURPOSE
//  Control unit for the add-shift signed multiplier datapath. Sequences the 16-bit A/B register pair
//  and the X sign flip-flop: clear, N add-or-skip / shift steps, then a final subtract step for
//  two's-complement. Sits between the board switches (Run, ClearA_LoadB) and the datapath enables.
// PARAMETERS
//  N       8   operand width = number of multiply steps (2..16)
//  CNT_W   4   step counter width, >= clog2(N)
// PORTS
//  Clk           in   1  system clock, rising edge
//  Reset_n       in   1  asynchronous, active-low reset
//  Run           in   1  start request, level; synchronous, debounced upstream
//  ClearA_LoadB  in   1  clear A/X and load B from switches; honoured only when not busy
//  M             in   1  current multiplier LSB (B[0]) from datapath
//  Clr_XA        out  1  synchronous clear of A register and X flip-flop
//  Ld_B          out  1  load B from switch bus
//  Add_en        out  1  A <= A + S (X <= sign of sum)
//  Sub_en        out  1  A <= A - S (X <= sign of difference)
//  Shift_en      out  1  arithmetic right shift of X:A:B by one
//  Busy          out  1  high from START through last SHIFT
//  Done          out  1  high in HOLD while product is valid
// BEHAVIOUR
//  - Reset (async, Reset_n=0): state IDLE, step counter 0, all outputs 0. Reset mid-operation
//    aborts immediately; datapath contents are not restored.
//  - States: IDLE, START, OP, SHIFT, HOLD. State and counter are registered; outputs are
//    combinational decodes of state, counter and M.
//  - IDLE: Run=1 -> START. ClearA_LoadB=1 -> Clr_XA=1, Ld_B=1 in the same cycle; state stays IDLE.
//  - START (1 cycle): Clr_XA=1, Busy=1, counter <= 0 -> OP.
//  - OP (1 cycle): M=1 and counter<N-1 -> Add_en=1; M=1 and counter==N-1 -> Sub_en=1; M=0 -> no
//    enable. Always -> SHIFT. Add_en and Sub_en are never high together.
//  - SHIFT (1 cycle): Shift_en=1. counter==N-1 -> HOLD, else counter <= counter+1, -> OP.
//  - HOLD: Done=1, Busy=0. Leaves only when Run=0 -> IDLE. Run held high never restarts.
//    ClearA_LoadB in HOLD behaves as in IDLE and leaves state unchanged.
//  - Latency: Run sampled high in IDLE -> Done high 2N+1 cycles later (17 for N=8).
//  - Run and ClearA_LoadB are ignored in START/OP/SHIFT. If both are high in IDLE, Run wins:
//    Ld_B=0, Clr_XA=0 that cycle, START next.
//  - Counter never exceeds N-1 and does not wrap. M is sampled only in OP.
//  - No illegal-state lockup: the default branch returns to IDLE with all outputs 0.
// STRUCTURE
//  - mult_pkg: typedef enum logic [2:0] {IDLE, START, OP, SHIFT, HOLD} mult_state_t;
//    localparam MULT_N = 8; shared with the datapath top and the testbench.
//  - One sub-module, mult_step_cnt: CNT_W-bit counter with clear, increment and last-step flag
//    (cnt==N-1). The FSM is kept in mult_ctrl itself.
//  - The A/B registers and the X flip-flop stay in the datapath; this block only drives enables.
// TESTING
//  1. Reset_n=0 for 2 cycles mid-idle -> all outputs 0. Assert Reset_n=0 at cycle 5 of a run ->
//     outputs 0 immediately (async); IDLE after release.
//  2. M=1 constant, Run pulse -> Clr_XA one cycle, 7 Add_en, 1 Sub_en (step 7), 8 Shift_en
//     alternating with OP; Done at cycle 17.
//  3. M=0 constant -> zero Add_en/Sub_en, 8 Shift_en, Done at cycle 17.
//  4. M pattern 1,0,1,1,0,0,1,0 (steps 0..7) -> Add_en on steps 0,2,3,6; no Sub_en; Done at 17.
//  5. Run held high 40 cycles -> exactly one multiply; Done stays high. Run 0 then 1 -> second
//     multiply starts.
//  6. ClearA_LoadB=1 in IDLE -> Clr_XA=Ld_B=1 same cycle. Same input during OP -> ignored.
//     Run and ClearA_LoadB high together in IDLE -> START, no Ld_B.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the add-shift signed multiplier.
//   MULT_N       operand width / number of multiply steps
//   MULT_CNT_W   step counter width for MULT_N
//   mult_state_t control FSM state encoding
package mult_pkg;

  localparam int MULT_N     = 8;
  localparam int MULT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    OP    = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_step_cnt.sv
// mult_step_cnt: multiply step counter.
//   Clk      in  clock, rising edge
//   Reset_n  in  asynchronous active-low reset (count -> 0)
//   clr      in  synchronous clear to 0 (has priority over inc)
//   inc      in  advance by one; ignored once the last step is reached
//   cnt      out current step index, 0..N-1
//   last     out high when cnt == N-1
module mult_step_cnt #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(N - 1));

  // Saturates at N-1 so the counter can never wrap into a stale step index.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// mult_ctrl: control unit for the add-shift signed multiplier datapath.
// Sequence per multiply: START (clear A/X), then N pairs of OP (add/skip, or
// subtract on the final step for the two's-complement sign weight) and SHIFT,
// then HOLD with the product valid until Run is released.
//   Clk           in  clock, rising edge
//   Reset_n       in  asynchronous active-low reset
//   Run           in  start request (level)
//   ClearA_LoadB  in  clear A/X and load B; honoured in IDLE and HOLD only
//   M             in  multiplier LSB B[0], used only in OP
//   Clr_XA        out clear A register and X flip-flop
//   Ld_B          out load B from switches
//   Add_en        out A <= A + S
//   Sub_en        out A <= A - S
//   Shift_en      out arithmetic right shift of X:A:B
//   Busy          out high in START, OP and SHIFT
//   Done          out high in HOLD
//
// Handshake: Run is a level request sampled on each rising edge in IDLE; after
// a multiply, Run must be seen low (HOLD -> IDLE) before another can start.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N     = MULT_N,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Add_en,
  output logic Sub_en,
  output logic Shift_en,
  output logic Busy,
  output logic Done
);

  mult_state_t      state, state_nxt;
  logic [CNT_W-1:0] step;
  logic             step_last;
  logic             cnt_clr;
  logic             cnt_inc;

  mult_step_cnt #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (step),
    .last    (step_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    Clr_XA    = 1'b0;
    Ld_B      = 1'b0;
    Add_en    = 1'b0;
    Sub_en    = 1'b0;
    Shift_en  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;

    // Outputs are also decodes of Run/ClearA_LoadB, so gate them while the
    // reset is asserted to keep every enable quiet during reset.
    if (Reset_n) begin
      case (state)
        IDLE: begin
          if (Run) begin
            state_nxt = START;
          end else if (ClearA_LoadB) begin
            Clr_XA = 1'b1;
            Ld_B   = 1'b1;
          end
        end
        START: begin
          Clr_XA    = 1'b1;
          Busy      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = OP;
        end
        OP: begin
          Busy      = 1'b1;
          // The multiplier MSB carries negative weight, so the last partial
          // product is subtracted instead of added.
          Add_en    = M && !step_last;
          Sub_en    = M && step_last;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          Busy     = 1'b1;
          Shift_en = 1'b1;
          if (step_last) begin
            state_nxt = HOLD;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = OP;
          end
        end
        HOLD: begin
          Done = 1'b1;
          if (ClearA_LoadB) begin
            Clr_XA = 1'b1;
            Ld_B   = 1'b1;
          end
          if (!Run) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: self-checking bench for mult_ctrl (N = 8).
// Observed vector order: {Clr_XA, Ld_B, Add_en, Sub_en, Shift_en, Busy, Done}.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int W = 7;

  logic Clk;
  logic Reset_n;
  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_XA, Ld_B, Add_en, Sub_en, Shift_en, Busy, Done;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int n_tests;
  int n_fail;

  localparam logic [W-1:0] V_IDLE  = 7'b0000000;
  localparam logic [W-1:0] V_CLLD  = 7'b1100000;
  localparam logic [W-1:0] V_START = 7'b1000010;
  localparam logic [W-1:0] V_SHIFT = 7'b0000110;
  localparam logic [W-1:0] V_HOLD  = 7'b0000001;

  mult_ctrl #(.N(MULT_N), .CNT_W(MULT_CNT_W)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Add_en       (Add_en),
    .Sub_en       (Sub_en),
    .Shift_en     (Shift_en),
    .Busy         (Busy),
    .Done         (Done)
  );

  assign obs = {Clr_XA, Ld_B, Add_en, Sub_en, Shift_en, Busy, Done};

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // One full multiply from IDLE: Run pulse, M driven per step from pat[k],
  // expected vectors pushed per cycle and compared at the following negedge.
  task automatic run_mult(input logic [7:0] pat, input logic cl_during, input string name);
    logic [W-1:0] e;
    int k;
    @(negedge Clk);
    Run = 1'b1;
    M   = pat[0];
    for (int j = 1; j <= 18; j++) begin
      @(posedge Clk);
      #1;
      Run          = 1'b0;
      ClearA_LoadB = cl_during && (j <= 17);
      if (j == 1) begin
        e = V_START;
      end else if (j == 18) begin
        e = V_HOLD;
      end else if ((j % 2) == 0) begin
        k = (j - 2) / 2;
        M = pat[k];
        e = {2'b00, pat[k] && (k < 7), pat[k] && (k == 7), 1'b0, 1'b1, 1'b0};
      end else begin
        e = V_SHIFT;
      end
      exp_q.push_back(e);
      @(negedge Clk);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, j, obs, e);
      end
    end
    // Run is low in HOLD, so the next edge returns to IDLE.
    @(posedge Clk);
    #1;
    exp_q.push_back(V_IDLE);
    @(negedge Clk);
    e = exp_q.pop_front();
    n_tests++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got %b expected %b", name, obs, e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected %b", obs, V_IDLE);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    Run = 1'b1;
    M   = 1'b1;
    @(posedge Clk);
    #1;
    Run = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    n_tests++;
    if (obs !== V_SHIFT) begin
      n_fail++;
      $display("FAIL reset_run_active: got %b expected %b", obs, V_SHIFT);
    end
    Reset_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", obs, V_IDLE);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, V_IDLE);
    end
    // ClearA_LoadB only decodes in IDLE/HOLD, so this shows we are back in IDLE.
    ClearA_LoadB = 1'b1;
    #1;
    n_tests++;
    if (obs !== V_CLLD) begin
      n_fail++;
      $display("FAIL reset_idle_after: got %b expected %b", obs, V_CLLD);
    end
    ClearA_LoadB = 1'b0;
  endtask

  task automatic test_run_held();
    int clr_cnt;
    int shift_cnt;
    clr_cnt   = 0;
    shift_cnt = 0;
    @(negedge Clk);
    Run = 1'b1;
    M   = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(negedge Clk);
      if (Clr_XA)   clr_cnt++;
      if (Shift_en) shift_cnt++;
    end
    n_tests++;
    if (clr_cnt != 1) begin
      n_fail++;
      $display("FAIL held_starts: got %0d expected 1", clr_cnt);
    end
    n_tests++;
    if (shift_cnt != 8) begin
      n_fail++;
      $display("FAIL held_shifts: got %0d expected 8", shift_cnt);
    end
    n_tests++;
    if (obs !== V_HOLD) begin
      n_fail++;
      $display("FAIL held_done: got %b expected %b", obs, V_HOLD);
    end
    Run = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL held_release: got %b expected %b", obs, V_IDLE);
    end
    run_mult(8'b1110_0101, 1'b0, "restart");
  endtask

  task automatic test_clear_load();
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    #1;
    n_tests++;
    if (obs !== V_CLLD) begin
      n_fail++;
      $display("FAIL cl_idle: got %b expected %b", obs, V_CLLD);
    end
    @(negedge Clk);
    n_tests++;
    if (obs !== V_CLLD) begin
      n_fail++;
      $display("FAIL cl_idle_stay: got %b expected %b", obs, V_CLLD);
    end
    ClearA_LoadB = 1'b0;
    run_mult(8'($urandom_range(0, 255)), 1'b1, "cl_ignored");
    // Run and ClearA_LoadB together: Run wins.
    @(negedge Clk);
    Run          = 1'b1;
    ClearA_LoadB = 1'b1;
    #1;
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL run_wins_same: got %b expected %b", obs, V_IDLE);
    end
    @(posedge Clk);
    #1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    M            = 1'b0;
    @(negedge Clk);
    n_tests++;
    if (obs !== V_START) begin
      n_fail++;
      $display("FAIL run_wins_start: got %b expected %b", obs, V_START);
    end
    repeat (17) @(posedge Clk);
    @(negedge Clk);
    n_tests++;
    if (obs !== V_HOLD) begin
      n_fail++;
      $display("FAIL run_wins_done: got %b expected %b", obs, V_HOLD);
    end
    @(negedge Clk);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    Reset_n      = 1'b0;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    M            = 1'b0;
    test_reset();
    run_mult(8'hFF, 1'b0, "m_ones");
    run_mult(8'h00, 1'b0, "m_zeros");
    run_mult(8'b0100_1101, 1'b0, "m_pattern");
    run_mult(8'($urandom_range(0, 255)), 1'b0, "m_random");
    test_run_held();
    test_clear_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
